// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM states, step count and counter width.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_WIDTH
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // A borrow out of the top bit means the divisor did not fit; keep the shifted remainder.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {1'b0, divisor_i};
    q_o     = ~trial[W];
    rem_o   = q_o ? trial[W-1:0] : shifted[W-1:0];
  end

endmodule : div_step

// File: rtl/divider.sv
// Multi-cycle signed/unsigned 32-bit divider for the E stage; stalls the pipe while busy.
module divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E_div_en,
  input  logic             E_div_signed,
  input  logic [WIDTH-1:0] E_div_src_a,
  input  logic [WIDTH-1:0] E_div_src_b,
  input  logic             E_div_cancel,
  output logic             E_div_stall,
  output logic             E_div_done,
  output logic [WIDTH-1:0] E_div_lo,
  output logic [WIDTH-1:0] E_div_hi
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes the quotient as bits shift in
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] dsr_q, dsr_d;     // divisor magnitude
  logic [WIDTH-1:0] a_raw_q, a_raw_d; // dividend as latched, for the divide-by-zero result
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             bz_q, bz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_next;
  logic             a_neg;
  logic             b_neg;

  div_step #(.W(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign quo_next = {dvd_q[WIDTH-2:0], step_q};
  assign a_neg    = E_div_signed & E_div_src_a[WIDTH-1];
  assign b_neg    = E_div_signed & E_div_src_b[WIDTH-1];

  // Hazard request: held through start and all iterations, released in DONE, on cancel and in reset.
  assign E_div_stall = ~rst & E_div_en & ~E_div_cancel & (state_q != DONE);

  assign E_div_done = done_q;
  assign E_div_lo   = lo_q;
  assign E_div_hi   = hi_q;

  // Next-state, iteration datapath and result fix-up on the final step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    a_raw_d = a_raw_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    bz_d    = bz_q;
    done_d  = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;

    unique case (state_q)
      IDLE: begin
        if (E_div_en && !E_div_cancel) begin
          state_d = BUSY;
          cnt_d   = '0;
          rem_d   = '0;
          dvd_d   = a_neg ? WIDTH'(~E_div_src_a + WIDTH'(1)) : E_div_src_a;
          dsr_d   = b_neg ? WIDTH'(~E_div_src_b + WIDTH'(1)) : E_div_src_b;
          a_raw_d = E_div_src_a;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          bz_d    = (E_div_src_b == '0);
        end
      end
      BUSY: begin
        if (E_div_cancel || !E_div_en) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          dvd_d = quo_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            if (bz_q) begin
              lo_d = '1;
              hi_d = a_raw_q;
            end else begin
              lo_d = q_neg_q ? WIDTH'(~quo_next + WIDTH'(1)) : quo_next;
              hi_d = r_neg_q ? WIDTH'(~step_rem + WIDTH'(1)) : step_rem;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      a_raw_q <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      a_raw_q <= a_raw_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      bz_q    <= bz_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule : divider

// File: tb/tb_divider.sv
// Directed and randomised bench for the E-stage divider with an expected-result queue.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        E_div_en;
  logic        E_div_signed;
  logic [31:0] E_div_src_a;
  logic [31:0] E_div_src_b;
  logic        E_div_cancel;
  logic        E_div_stall;
  logic        E_div_done;
  logic [31:0] E_div_lo;
  logic [31:0] E_div_hi;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  divider #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .E_div_en     (E_div_en),
    .E_div_signed (E_div_signed),
    .E_div_src_a  (E_div_src_a),
    .E_div_src_b  (E_div_src_b),
    .E_div_cancel (E_div_cancel),
    .E_div_stall  (E_div_stall),
    .E_div_done   (E_div_done),
    .E_div_lo     (E_div_lo),
    .E_div_hi     (E_div_hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic truncates toward zero, remainder takes the dividend's sign.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    qv = 64'(q);
    rv = 64'(r);
    return {qv[31:0], rv[31:0]};
  endfunction

  // Called at posedge+1; returns in the DONE cycle at posedge+2 with en set to keep_en.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi, input logic keep_en);
    int          stalls;
    bit          got;
    logic [63:0] exp;
    sb_q.push_back({elo, ehi});
    E_div_signed = sgn;
    E_div_src_a  = a;
    E_div_src_b  = b;
    E_div_en     = 1'b1;
    stalls = 0;
    got    = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (E_div_done) begin
        got = 1'b1;
        break;
      end
      if (E_div_stall) stalls++;
      @(posedge clk);
      #1;
      E_div_src_a  = $urandom();
      E_div_src_b  = $urandom();
      E_div_signed = ~sgn;
    end
    check("done_seen", 32'(got), 32'd1);
    check("stall_len", 32'(stalls), 32'd33);
    if (got) begin
      check("stall_at_done", 32'(E_div_stall), 32'd0);
      exp = sb_q.pop_front();
      check("lo", E_div_lo, exp[63:32]);
      check("hi", E_div_hi, exp[31:0]);
    end else begin
      sb_q.delete();
    end
    E_div_en = keep_en;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] m;
    logic        bad;

    rst          = 1'b1;
    E_div_en     = 1'b1;
    E_div_signed = 1'b0;
    E_div_src_a  = 32'd0;
    E_div_src_b  = 32'd0;
    E_div_cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(E_div_stall), 32'd0);
    check("rst_done", 32'(E_div_done), 32'd0);
    check("rst_lo", E_div_lo, 32'd0);
    check("rst_hi", E_div_hi, 32'd0);
    E_div_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    @(posedge clk); #1;
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk); #1;
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    @(posedge clk); #1;
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    @(posedge clk); #1;
    do_div(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    @(posedge clk); #1;
    do_div(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      ra = $urandom();
      rb = (i < 3) ? ($urandom() >> (i * 8)) | 32'd1 : 32'($urandom_range(1, 1000));
      rs = i[0];
      m  = model(rs, ra, rb);
      do_div(rs, ra, rb, m[63:32], m[31:0], 1'b0);
      @(posedge clk); #1;
    end

    // Known result, then a divide cancelled at T10 must leave it untouched.
    do_div(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
    @(posedge clk); #1;
    E_div_signed = 1'b0;
    E_div_src_a  = 32'd77;
    E_div_src_b  = 32'd4;
    E_div_en     = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    E_div_cancel = 1'b1;
    #1;
    check("cancel_stall", 32'(E_div_stall), 32'd0);
    @(posedge clk); #1;
    check("cancel_done", 32'(E_div_done), 32'd0);
    check("cancel_lo_kept", E_div_lo, 32'd10);
    check("cancel_hi_kept", E_div_hi, 32'd0);
    E_div_cancel = 1'b0;
    do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    @(posedge clk); #1;

    // Dropping en mid-divide behaves as a cancel.
    E_div_signed = 1'b0;
    E_div_src_a  = 32'd1000;
    E_div_src_b  = 32'd3;
    E_div_en     = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    E_div_en = 1'b0;
    @(posedge clk); #1;
    check("endrop_done", 32'(E_div_done), 32'd0);
    check("endrop_lo_kept", E_div_lo, 32'd3);
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a divide.
    E_div_signed = 1'b0;
    E_div_src_a  = 32'd200;
    E_div_src_b  = 32'd9;
    E_div_en     = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst_stall", 32'(E_div_stall), 32'd0);
    check("arst_done", 32'(E_div_done), 32'd0);
    check("arst_lo", E_div_lo, 32'd0);
    check("arst_hi", E_div_hi, 32'd0);
    @(posedge clk); #2;
    E_div_en = 1'b0;
    rst      = 1'b0;
    bad      = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      bad = bad | E_div_done | E_div_stall;
    end
    check("idle_after_rst", 32'(bad), 32'd0);
    check("no_stale_lo", E_div_lo, 32'd0);
    @(posedge clk); #1;
    do_div(1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_divider

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: E_div_en  input  1  a DIV/DIVU instruction occupies the E stage.
REQ-005 Port: E_div_signed  input  1  1 = DIV (signed), 0 = DIVU.
REQ-006 Port: E_div_src_a  input  WIDTH  dividend, forwarded E-stage rs value.
REQ-007 Port: E_div_src_b  input  WIDTH  divisor, forwarded E-stage rt value.
REQ-008 Port: E_div_cancel  input  1  kill the in-flight divide; driven by M_except.
REQ-009 Port: E_div_stall  output  1  combinational; the hazard unit holds F/D/E/M/W while this is high.
REQ-010 Port: E_div_done  output  1  registered; result valid this cycle.
REQ-011 Port: E_div_lo  output  WIDTH  quotient, registered.
REQ-012 Port: E_div_hi  output  WIDTH  remainder, registered.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-014 Start: in IDLE with E_div_en=1 and E_div_cancel=0, the block SHALL latch the operands, the signedness and the divisor-zero flag, clear the 6-bit iteration counter, and enter BUSY. This is cycle T0.
REQ-015 Operand changes after T0 SHALL be ignored.
REQ-016 BUSY SHALL perform one restoring-division step per cycle on the operand magnitudes, MSB first. BUSY SHALL last exactly 32 cycles (T1..T32) and then enter DONE at T33.
REQ-017 E_div_stall SHALL be E_div_en & ~E_div_cancel & (state != DONE). It is therefore high for exactly T0..T32 (33 cycles) and low at T33.
REQ-018 DONE SHALL last one cycle with E_div_done=1 and the results valid, then return to IDLE.
REQ-019 E_div_lo and E_div_hi SHALL hold their value until the next DONE.
REQ-020 Unsigned mode: quotient and remainder SHALL be the plain 32-bit results.
REQ-021 Signed mode: quotient sign SHALL be a[31]^b[31] and remainder sign SHALL be a[31]. Negation is two's complement, so 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0.
REQ-022 Divisor zero, either mode: the result SHALL be lo=0xFFFFFFFF and hi=dividend as latched, with no sign correction. The stall length SHALL be unchanged.
REQ-023 Cancel: E_div_cancel=1 in any state SHALL force E_div_stall=0 in that cycle and state=IDLE at the next edge. E_div_done SHALL NOT assert for the cancelled operation, and the result registers SHALL remain unchanged.
REQ-024 If E_div_en drops while in BUSY, it SHALL be treated identically to a cancel.
REQ-025 Back-to-back divides: a DIV entering E in the cycle after DONE SHALL start normally from IDLE.
REQ-026 Simultaneous start and cancel in IDLE: no start SHALL occur and stall SHALL be 0.

Reset
REQ-027 While rst=1, the block SHALL force state=IDLE, counter=0, E_div_done=0, E_div_lo=0, E_div_hi=0, and E_div_stall=0, independent of clk.
REQ-028 Reset asserted mid-BUSY SHALL abort the operation, and no stale result SHALL appear after release.

Structure
REQ-029 A shared package div_pkg SHALL hold the state enumeration (IDLE, BUSY, DONE), DIV_STEPS=32 and the counter width 6.
REQ-030 One combinational sub-module div_step SHALL perform a single restoring iteration. It takes the partial remainder, the next dividend bit and the divisor, and returns the new remainder and the quotient bit.
REQ-031 Sign fix-up and the divisor-zero override SHALL be in divider, applied when entering DONE.

Verification
REQ-032 DIVU 100/7, en held: stall=1 for exactly 33 cycles, then done=1 at T33 with lo=14, hi=2.
REQ-033 DIV 0xFFFFFFF9/2 (-7/2): lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/0xFFFFFFFE: lo=0xFFFFFFFD, hi=1.
REQ-034 DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0, with no hang and the same 33-cycle stall.
REQ-035 DIVU and DIV 0x12345678/0: lo=0xFFFFFFFF, hi=0x12345678, with the normal stall length.
REQ-036 Cancel at T10: stall=0 in the same cycle and IDLE at the next edge; done never asserts and the prior lo/hi are retained. A new DIVU 9/3 the next cycle gives lo=3, hi=0 after 33 stall cycles.
REQ-037 rst pulse at T20, asynchronous to clk: all outputs are 0 immediately. After release with en=0, the block stays IDLE with stall=0.
